// File: rtl/test_status_monitor.sv
// ---------------------------------------------------------------------------
// test_status_monitor
//
// End-of-test monitor placed downstream of the RV64I core. It watches the
// core PC and the register write-back port. It keeps a shadow copy of the
// verdict register and detects completion when the PC reaches a fixed address.
// On completion it freezes the core through halt and reports pass, fail or
// timeout. It also reports cycle and write-back counts, so regressions need
// no hierarchical peeks into the core.
//
// Ports:
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous active-low reset
//   start      in   1      one-cycle pulse that begins a run
//   pc_i       in   XLEN   core program counter
//   wb_en      in   1      register-file write enable
//   wb_rd      in   5      destination register index
//   wb_data    in   XLEN   write-back data
//   halt       out  1      freeze request, high in DONE and TIMEOUT
//   done       out  1      run ended by reaching DONE_PC
//   pass       out  1      done with shadow result == 0
//   timeout    out  1      run exceeded MAX_CYCLES
//   result     out  XLEN   shadow of register RESULT_REG
//   cycle_cnt  out  CNT_W  cycles spent in RUN (saturating)
//   wb_cnt     out  CNT_W  write-backs to non-zero registers (saturating)
// ---------------------------------------------------------------------------
module test_status_monitor #(
    parameter int unsigned      XLEN       = 64,
    parameter logic [XLEN-1:0]  DONE_PC    = 64'h0000_001c,
    parameter int unsigned      RESULT_REG = 3,
    parameter int unsigned      MAX_CYCLES = 100000,
    parameter int unsigned      CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             halt,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [XLEN-1:0]  result,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] wb_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_DONE    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    localparam logic [4:0]  LP_RES_REG   = 5'(RESULT_REG);
    // Counter value at which one more RUN cycle exhausts the budget.
    localparam logic [63:0] LP_CYC_LAST  = 64'(MAX_CYCLES) - 64'd1;
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    state_t            r_state;
    logic              r_halt;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic [XLEN-1:0]   r_result;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_wb_cnt;

    logic              w_wb_live;
    logic [XLEN-1:0]   w_result_next;
    logic              w_at_done;
    logic              w_cyc_last;
    logic [CNT_W-1:0]  w_cycle_inc;
    logic [CNT_W-1:0]  w_wb_inc;

    // Next-value helpers for the RUN state: write-back filtering, shadow
    // result forwarding and saturating counter increments.
    always_comb begin
        w_wb_live     = wb_en && (wb_rd != 5'd0);
        w_at_done     = (pc_i == DONE_PC);
        w_cyc_last    = (64'(r_cycle_cnt) == LP_CYC_LAST);
        w_result_next = r_result;
        if (w_wb_live && (wb_rd == LP_RES_REG)) begin
            w_result_next = wb_data;
        end else begin
            w_result_next = r_result;
        end
        if (&r_cycle_cnt) begin
            w_cycle_inc = r_cycle_cnt;
        end else begin
            w_cycle_inc = r_cycle_cnt + LP_ONE;
        end
        if (&r_wb_cnt) begin
            w_wb_inc = r_wb_cnt;
        end else begin
            w_wb_inc = r_wb_cnt + LP_ONE;
        end
    end

    // Run-control FSM with all reported outputs held in registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_halt      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_result    <= '0;
            r_cycle_cnt <= '0;
            r_wb_cnt    <= '0;
        end else begin
            case (r_state)
                // Idle and both terminal states share the restart path;
                // otherwise everything holds and write-backs are ignored.
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_halt      <= 1'b0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_result    <= '0;
                        r_cycle_cnt <= '0;
                        r_wb_cnt    <= '0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_RUN: begin
                    r_cycle_cnt <= w_cycle_inc;
                    r_result    <= w_result_next;
                    if (w_wb_live) begin
                        r_wb_cnt <= w_wb_inc;
                    end else begin
                        r_wb_cnt <= r_wb_cnt;
                    end
                    // Completion beats timeout; the verdict uses the
                    // forwarded result so a same-cycle x3 write counts.
                    if (w_at_done) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_halt  <= 1'b1;
                        r_pass  <= (w_result_next == '0);
                    end else if (w_cyc_last) begin
                        r_state   <= ST_TIMEOUT;
                        r_timeout <= 1'b1;
                        r_halt    <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_halt      <= 1'b0;
                    r_done      <= 1'b0;
                    r_pass      <= 1'b0;
                    r_timeout   <= 1'b0;
                    r_result    <= '0;
                    r_cycle_cnt <= '0;
                    r_wb_cnt    <= '0;
                end
            endcase
        end
    end

    assign halt      = r_halt;
    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign result    = r_result;
    assign cycle_cnt = r_cycle_cnt;
    assign wb_cnt    = r_wb_cnt;

endmodule

// File: tb/tb_test_status_monitor.sv
// ---------------------------------------------------------------------------
// Bench for test_status_monitor. It runs two instances on shared stimulus.
//   A: MAX_CYCLES=16,   CNT_W=32  (timeout behaviour)
//   B: MAX_CYCLES=1000, CNT_W=3   (counter saturation)
// A run-level reference model tracks unbounded true counts. The model applies
// saturation only when it forms the expected value.
// ---------------------------------------------------------------------------
module tb_test_status_monitor;

    localparam logic [63:0] DONE_PC = 64'h0000_001c;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] pc_i = 64'd0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [63:0] wb_data = 64'd0;

    logic        halt_a, done_a, pass_a, timeout_a;
    logic [63:0] result_a;
    logic [31:0] cyc_a, wbc_a;
    logic        halt_b, done_b, pass_b, timeout_b;
    logic [63:0] result_b;
    logic [2:0]  cyc_b, wbc_b;

    test_status_monitor #(.MAX_CYCLES(16), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .start(start), .pc_i(pc_i), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .halt(halt_a), .done(done_a),
        .pass(pass_a), .timeout(timeout_a), .result(result_a),
        .cycle_cnt(cyc_a), .wb_cnt(wbc_a)
    );

    test_status_monitor #(.MAX_CYCLES(1000), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .pc_i(pc_i), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .halt(halt_b), .done(done_b),
        .pass(pass_b), .timeout(timeout_b), .result(result_b),
        .cycle_cnt(cyc_b), .wb_cnt(wbc_b)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state, one entry per instance.
    bit          m_run  [2];
    bit          m_done [2];
    bit          m_pass [2];
    bit          m_to   [2];
    logic [63:0] m_res  [2];
    longint      m_cyc  [2];
    longint      m_wb   [2];
    longint      m_max  [2] = '{16, 1000};
    longint      m_cap  [2] = '{64'hFFFF_FFFF, 7};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_to[k] = 0;
            m_res[k] = 64'd0; m_cyc[k] = 0; m_wb[k] = 0;
        end
    endtask

    // One clock edge of the run rules, applied to the inputs seen at that edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!m_run[k]) begin
                if (start) begin
                    m_run[k] = 1; m_done[k] = 0; m_pass[k] = 0; m_to[k] = 0;
                    m_res[k] = 64'd0; m_cyc[k] = 0; m_wb[k] = 0;
                end
            end else begin
                m_cyc[k]++;
                if (wb_en && wb_rd != 5'd0) begin
                    m_wb[k]++;
                    if (wb_rd == 5'd3) m_res[k] = wb_data;
                end
                if (pc_i == DONE_PC) begin
                    m_run[k] = 0; m_done[k] = 1; m_pass[k] = (m_res[k] == 64'd0);
                end else if (m_cyc[k] == m_max[k]) begin
                    m_run[k] = 0; m_to[k] = 1;
                end
            end
        end
    endtask

    function automatic logic [63:0] sat(input longint v, input longint cap);
        return (v > cap) ? 64'(cap) : 64'(v);
    endfunction

    task automatic check_outputs();
        check_val("A.halt",    {63'd0, halt_a},    {63'd0, m_done[0] | m_to[0]});
        check_val("A.done",    {63'd0, done_a},    {63'd0, m_done[0]});
        check_val("A.pass",    {63'd0, pass_a},    {63'd0, m_pass[0]});
        check_val("A.timeout", {63'd0, timeout_a}, {63'd0, m_to[0]});
        check_val("A.result",  result_a,           m_res[0]);
        check_val("A.cycle",   {32'd0, cyc_a},     sat(m_cyc[0], m_cap[0]));
        check_val("A.wbcnt",   {32'd0, wbc_a},     sat(m_wb[0], m_cap[0]));
        check_val("B.halt",    {63'd0, halt_b},    {63'd0, m_done[1] | m_to[1]});
        check_val("B.done",    {63'd0, done_b},    {63'd0, m_done[1]});
        check_val("B.pass",    {63'd0, pass_b},    {63'd0, m_pass[1]});
        check_val("B.timeout", {63'd0, timeout_b}, {63'd0, m_to[1]});
        check_val("B.result",  result_b,           m_res[1]);
        check_val("B.cycle",   {61'd0, cyc_b},     sat(m_cyc[1], m_cap[1]));
        check_val("B.wbcnt",   {61'd0, wbc_b},     sat(m_wb[1], m_cap[1]));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic s, input logic [63:0] pc, input logic en,
                         input logic [4:0] rd, input logic [63:0] d);
        start = s; pc_i = pc; wb_en = en; wb_rd = rd; wb_data = d;
        step();
    endtask

    function automatic logic [63:0] busy_pc();
        return 64'(4 * $urandom_range(0, 6));
    endfunction

    initial begin
        model_reset();
        #12;
        check_outputs();
        rst = 1'b1;
        drive(1'b0, 64'd0, 1'b1, 5'd3, 64'd9);        // idle: ignored
        check_val("idle.result", result_a, 64'd0);

        // Pass run
        drive(1'b1, 64'd0, 1'b0, 5'd0, 64'd0);
        drive(1'b0, 64'd4, 1'b1, 5'd3, 64'd5);
        drive(1'b0, 64'd8, 1'b1, 5'd3, 64'd0);
        drive(1'b0, DONE_PC, 1'b0, 5'd0, 64'd0);
        check_val("plan.pass",  {63'd0, pass_a}, 64'd1);
        check_val("plan.halt",  {63'd0, halt_a}, 64'd1);
        check_val("plan.wbcnt", {32'd0, wbc_a},  64'd2);
        check_val("plan.cycle", {32'd0, cyc_a},  64'd3);
        drive(1'b0, 64'd4, 1'b1, 5'd3, 64'd1);        // extra core cycle ignored

        // Fail run, then a write while in DONE
        drive(1'b1, 64'd0, 1'b0, 5'd0, 64'd0);
        check_val("b2b.clear", {32'd0, cyc_a}, 64'd0);
        drive(1'b0, 64'd4, 1'b1, 5'd3, 64'd7);
        drive(1'b0, DONE_PC, 1'b0, 5'd0, 64'd0);
        drive(1'b0, 64'd4, 1'b1, 5'd3, 64'd0);
        check_val("fail.result", result_a, 64'd7);
        check_val("fail.pass",   {63'd0, pass_a}, 64'd0);

        // Same-cycle write, x0 write, start together with done PC
        drive(1'b1, 64'd0, 1'b0, 5'd0, 64'd0);
        drive(1'b0, 64'd4, 1'b1, 5'd3, 64'd1);
        drive(1'b0, 64'd8, 1'b1, 5'd0, 64'd9);
        check_val("x0.wbcnt", {32'd0, wbc_a}, 64'd1);
        drive(1'b1, DONE_PC, 1'b1, 5'd3, 64'd0);
        check_val("same.pass", {63'd0, pass_a}, 64'd1);

        // Back-to-back run with a mid-run start, verdict 3
        drive(1'b1, 64'd0, 1'b0, 5'd0, 64'd0);
        drive(1'b0, 64'd4, 1'b1, 5'd3, 64'd3);
        drive(1'b1, 64'd8, 1'b0, 5'd0, 64'd0);
        check_val("midstart.cycle", {32'd0, cyc_a}, 64'd2);
        drive(1'b0, DONE_PC, 1'b0, 5'd0, 64'd0);
        check_val("b2b.pass", {63'd0, pass_a}, 64'd0);

        // Timeout at 16 RUN cycles, then done on exactly cycle 16
        drive(1'b1, 64'd0, 1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 18; i++) drive(1'b0, busy_pc(), 1'b1, 5'd5, 64'd1);
        check_val("to.timeout", {63'd0, timeout_a}, 64'd1);
        check_val("to.cycle",   {32'd0, cyc_a},     64'd16);
        check_val("sat.wbcnt",  {61'd0, wbc_b},     64'd7);
        drive(1'b1, 64'd0, 1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 15; i++) drive(1'b0, busy_pc(), 1'b0, 5'd0, 64'd0);
        drive(1'b0, DONE_PC, 1'b0, 5'd0, 64'd0);
        check_val("edge.done",    {63'd0, done_a},    64'd1);
        check_val("edge.timeout", {63'd0, timeout_a}, 64'd0);

        // Asynchronous reset mid-run
        drive(1'b1, 64'd0, 1'b0, 5'd0, 64'd0);
        drive(1'b0, 64'd4, 1'b1, 5'd3, 64'd4);
        drive(1'b0, 64'd8, 1'b1, 5'd3, 64'd6);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check_val("arst.result", result_a, 64'd0);
        step();
        #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, busy_pc(), 1'b1, 5'd3, 64'd2);
        check_val("arst.idle", {32'd0, cyc_a}, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        s, en;
            logic [63:0] pc, d;
            logic [4:0]  rd;
            int          pick;
            s    = ($urandom_range(0, 9) == 0);
            pc   = ($urandom_range(0, 11) == 0) ? DONE_PC : busy_pc();
            en   = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 3));
            rd   = (pick == 0) ? 5'd0 : (pick == 1) ? 5'd3 : 5'($urandom_range(1, 31));
            d    = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
            drive(s, pc, en, rd, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/test_status_monitor.md
# test_status_monitor

Hardware end-of-test monitor that sits directly downstream of the RV64I core. It watches the core's program counter and register write-back port, keeps a shadow copy of the result register (x3), and detects program completion at a fixed PC. It then freezes the core via `halt` and reports pass, fail or timeout with cycle and write-back counts, so regression runs (single test or back-to-back sweeps) do not depend on hierarchical peeks.

## Interface
- `XLEN`, 64: data and PC width.
- `DONE_PC`, 64'h0000001c: PC value that marks end of program.
- `RESULT_REG`, 3: architectural register whose final value is the test verdict (0 = pass).
- `MAX_CYCLES`, 100000: cycle budget per run before timeout.
- `CNT_W`, 32: width of the cycle and write-back counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low; the block is held in reset while `rst`=0.
- `start`  in  1  one-cycle pulse that begins a run.
- `pc_i`  in  XLEN  core's current PC.
- `wb_en`  in  1  register-file write enable from the core.
- `wb_rd`  in  5  destination register index.
- `wb_data`  in  XLEN  write-back data.
- `halt`  out  1  freezes the core; high in DONE and TIMEOUT.
- `done`  out  1  run finished by reaching `DONE_PC`.
- `pass`  out  1  `done` and shadow result == 0.
- `timeout`  out  1  run exceeded `MAX_CYCLES`.
- `result`  out  XLEN  shadow of register `RESULT_REG`.
- `cycle_cnt`  out  CNT_W  cycles spent in RUN.
- `wb_cnt`  out  CNT_W  retired write-backs with `wb_rd`≠0.

## Operation
- States: IDLE, RUN, DONE, TIMEOUT. Encoding is free.
- IDLE: counters hold. On `start`: go to RUN, clear `cycle_cnt`, `wb_cnt`, `result`, `done`, `pass`, `timeout`.
- RUN:
  - `cycle_cnt` increments by 1 every cycle.
  - Write-back with `wb_en`=1 and `wb_rd`≠0 increments `wb_cnt`.
  - If `wb_rd`==`RESULT_REG`, `result` loads `wb_data`.
  - Writes to x0 are ignored entirely.
- RUN→DONE when `pc_i`==`DONE_PC`. `pass` is evaluated on the next value of `result`, so a write-back to `RESULT_REG` in the same cycle counts.
- RUN→TIMEOUT when `cycle_cnt`==`MAX_CYCLES`−1 and `pc_i`≠`DONE_PC`. If both conditions hold in the same cycle, DONE wins.
- DONE/TIMEOUT: all outputs hold and write-backs are ignored. `start` re-enters RUN with everything cleared (back-to-back test sweep).
- `start` while in RUN is ignored. `start` in the same cycle as a DONE condition is also ignored; the run still completes.
- Counters saturate at all-ones and never wrap.
- Reset mid-run: every output returns to its reset value immediately, asynchronously. The state returns to IDLE.

## Timing
- Reset values: state IDLE; `halt`, `done`, `pass`, `timeout`=0; `result`, `cycle_cnt`, `wb_cnt`=0.
- All outputs are registered; there are no combinational input-to-output paths.
- `start` sampled at edge N: RUN from edge N. The first counted cycle is the one after edge N, so `cycle_cnt`=1 after edge N+1.
- `pc_i`==`DONE_PC` sampled at edge M: `done`, `halt` and `pass` are valid after edge M (1-cycle latency).
- `cycle_cnt` freezes at its value from edge M.
- The core sees `halt` one cycle after the done PC is first presented. The core must tolerate one extra cycle; the monitor ignores anything it does in that cycle.
- Timeout: `timeout` and `halt` rise at the edge where `cycle_cnt` would reach `MAX_CYCLES`. `cycle_cnt` then reads `MAX_CYCLES`.

## Test plan
- **Pass run:** reset, `start`, write x3=5, then x3=0, then `pc_i`=0x1c → one cycle later `done`=1, `pass`=1, `halt`=1, `result`=0, `wb_cnt`=2.
- **Fail run:** x3=7 is the last write before `pc_i`=0x1c → `done`=1, `pass`=0, `result`=7. A later write x3=0 while in DONE leaves `result`=7.
- **Same-cycle write:** x3=0 written in the same cycle `pc_i`=0x1c → `pass`=1. Writes to x0 with `wb_data`=9 → `wb_cnt` unchanged.
- **Timeout:** `MAX_CYCLES`=16, `pc_i` never 0x1c → `timeout`=1, `halt`=1, `done`=0 after 16 RUN cycles. With 0x1c presented on cycle 16, `done`=1 and `timeout`=0.
- **Back-to-back:** after DONE, pulse `start` → all flags and counters clear within 1 cycle. Second run with x3=3 → `pass`=0. `start` pulsed mid-run → no effect.
- **Async reset mid-run:** drop `rst` between edges → outputs 0 immediately with no clock edge. Release `rst` → IDLE, no counting until `start`.
